cache_read_axi4_bridge: RTL

CACHE_READ_AXI4_BRIDGE -- requirements
Module: cache_read_axi4_bridge

---
 rtl/cache_read_axi4_bridge.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cache_read_axi4_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cache_read_axi4_bridge
// Brief    : Turns single cache-line refill requests into fixed-length AXI4
//            INCR read bursts and streams the returned beats to the cache
//            through a small elastic buffer. One burst outstanding at a time.
// Option   : CACHE_BRIDGE_RRESP_CHECK_EN - when defined, beats returned with
//            SLVERR/DECERR are flagged on S_RERR; otherwise S_RERR is 0.
// Revision : 1.0 - initial release
// ============================================================================
module cache_read_axi4_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_BEATS = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  // cache refill request
  input  logic [ADDR_WIDTH-1:0] S_ARADDR,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  // refill data to cache
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic                  S_RVALID,
  output logic                  S_RLAST,
  output logic                  S_RERR,
  input  logic                  S_RREADY,
  // AXI4 read address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARID,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  // AXI4 read data channel
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  // status
  output logic                  busy,
  output logic                  proto_err
);

  localparam int c_ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [7:0] c_LAST_BEAT = 8'(BURST_BEATS - 1);
`ifdef CACHE_BRIDGE_RRESP_CHECK_EN
  localparam int c_ENTRY_W = DATA_WIDTH + 2;  // {err, last, data}
`else
  localparam int c_ENTRY_W = DATA_WIDTH + 1;  // {last, data}
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [7:0]              r_beat_cnt;
  logic                    r_proto_err;
  logic [c_ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_PTR_W:0]        r_wr_ptr;
  logic [c_PTR_W:0]        r_rd_ptr;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_last_calc;
  logic                    w_ar_hs;
  logic                    w_m_ar_hs;
  logic                    w_r_hs;
  logic                    w_pop;
  logic [c_ENTRY_W-1:0]    w_entry;
  logic [c_ENTRY_W-1:0]    w_head;
  logic                    w_unused;

  // Fixed burst shape: full-width beats, incrementing, single ID.
  assign M_AXI_ARLEN   = c_LAST_BEAT;
  assign M_AXI_ARSIZE  = 3'(c_ADDR_LSB);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARID    = 1'b0;
  assign M_AXI_ARADDR  = r_araddr;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_last_calc = (r_beat_cnt == c_LAST_BEAT);
  assign w_ar_hs     = S_ARVALID && S_ARREADY;
  assign w_m_ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
  assign w_r_hs      = M_AXI_RVALID && M_AXI_RREADY;
  assign w_pop       = S_RVALID && S_RREADY;

  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign proto_err = r_proto_err;

  // Sub-beat address bits and RRESP[0] carry no information for this bridge.
  assign w_unused = &{1'b0, M_AXI_RRESP, S_ARADDR[c_ADDR_LSB-1:0]};

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_state_next;
  end

  // Next state and handshake outputs; ARVALID derives from state only.
  always_comb begin
    w_state_next  = r_state;
    S_ARREADY     = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (r_state)
      S_IDLE: begin
        S_ARREADY = 1'b1;
        if (S_ARVALID) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) w_state_next = S_DATA;
      end
      S_DATA: begin
        M_AXI_RREADY = !w_full;
        // The burst ends on our own beat count, whatever RLAST claims.
        if (M_AXI_RVALID && !w_full && w_last_calc) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the beat-aligned refill address when a request is accepted.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_araddr <= '0;
    else if (w_ar_hs)   r_araddr <= {S_ARADDR[ADDR_WIDTH-1:c_ADDR_LSB], {c_ADDR_LSB{1'b0}}};
  end

  // Beat counter: cleared when the address is taken, advanced per accepted beat.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_beat_cnt <= '0;
    else if (w_m_ar_hs) r_beat_cnt <= '0;
    else if (w_r_hs)    r_beat_cnt <= r_beat_cnt + 8'd1;
  end

  // Sticky flag for an RLAST that disagrees with the expected burst end.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)                               r_proto_err <= 1'b0;
    else if (w_r_hs && (M_AXI_RLAST != w_last_calc)) r_proto_err <= 1'b1;
  end

`ifdef CACHE_BRIDGE_RRESP_CHECK_EN
  assign w_entry = {M_AXI_RRESP[1], w_last_calc, M_AXI_RDATA};
`else
  assign w_entry = {w_last_calc, M_AXI_RDATA};
`endif

  // Beat buffer storage; contents need no reset since the pointers gate them.
  always_ff @(posedge M_AXI_ACLK) begin
    if (w_r_hs) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_entry;
  end

  // Buffer pointers; push and pop are independent so both may fire together.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_r_hs) r_wr_ptr <= r_wr_ptr + (c_PTR_W + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_PTR_W + 1)'(1);
    end
  end

  assign w_head   = r_mem[r_rd_ptr[c_PTR_W-1:0]];
  assign S_RVALID = !w_empty;
  assign S_RDATA  = w_head[DATA_WIDTH-1:0];
  assign S_RLAST  = w_head[DATA_WIDTH];
`ifdef CACHE_BRIDGE_RRESP_CHECK_EN
  assign S_RERR   = w_head[DATA_WIDTH+1];
`else
  assign S_RERR   = 1'b0;
`endif

endmodule
`default_nettype wire
